// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared state, error-code and SOF encodings for the UART command frame receiver
package uart_cmd_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CHK, COMMIT} state_t;
    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_BAD_LEN = 3'd1,
        ERR_BAD_CHK = 3'd2,
        ERR_TIMEOUT = 3'd3,
        ERR_OVERRUN = 3'd4
    } err_t;
    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_cmd_payload_buf.sv
// uart_cmd_payload_buf: payload register file with one write port and asynchronous read
module uart_cmd_payload_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_cmd_rx_ctrl.sv
// uart_cmd_rx_ctrl: parses SOF/ADDR/LEN/payload[/CHK] frames and commits them as register writes; CHK byte built only with UART_CMD_CHKSUM_EN
module uart_cmd_rx_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int         MAX_LEN  = 16,
    parameter logic [7:0] SOF_BYTE = SOF_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_data_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_endofpacket,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic       frame_err,
    output logic [2:0] err_code
);
    localparam int         AW    = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_B = 8'(MAX_LEN);
    state_t        state;
    logic [7:0]    base, len, idx, nxt, rdata;
    logic          ovr_pend, hs, last, we;
    logic [AW-1:0] rd_idx;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]    chk;
`endif
    assign nxt    = idx + 8'd1;
    assign last   = nxt == len;
    assign hs     = wr_valid && wr_ready;
    assign we     = rx_data_ready && state == DATA;
    assign rd_idx = state == COMMIT ? nxt[AW-1:0] : '0;
    uart_cmd_payload_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (idx[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_idx),
        .rdata (rdata)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base       <= '0;
            len        <= '0;
            idx        <= '0;
            ovr_pend   <= 1'b0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
`ifdef UART_CMD_CHKSUM_EN
            chk        <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            frame_err  <= ovr_pend;
            ovr_pend   <= 1'b0;
            if (ovr_pend) err_code <= ERR_OVERRUN;
            if (state == COMMIT) begin
                if (hs) begin
                    idx     <= nxt;
                    wr_addr <= wr_addr + 8'd1;
                    wr_data <= rdata;
                    if (last) begin
                        state      <= IDLE;
                        wr_valid   <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                if (rx_data_ready) begin
                    if (hs && last) ovr_pend <= 1'b1;
                    else begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_OVERRUN;
                    end
                end
            end else if (rx_data_ready) begin
                case (state)
                    IDLE: if (rx_data == SOF_BYTE) state <= ADDR;
                    ADDR: begin
                        base  <= rx_data;
                        state <= LEN;
`ifdef UART_CMD_CHKSUM_EN
                        chk   <= rx_data;
`endif
                    end
                    LEN: if (rx_data == 8'd0 || rx_data > MAX_B) begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_BAD_LEN;
                        state     <= IDLE;
                    end else begin
                        len   <= rx_data;
                        idx   <= '0;
                        state <= DATA;
`ifdef UART_CMD_CHKSUM_EN
                        chk   <= chk ^ rx_data;
`endif
                    end
                    DATA: begin
                        idx <= nxt;
`ifdef UART_CMD_CHKSUM_EN
                        chk <= chk ^ rx_data;
                        if (last) state <= CHK;
`else
                        if (last) begin
                            state    <= COMMIT;
                            idx      <= '0;
                            wr_valid <= 1'b1;
                            wr_addr  <= base;
                            wr_data  <= idx == 8'd0 ? rx_data : rdata;
                        end
`endif
                    end
`ifdef UART_CMD_CHKSUM_EN
                    CHK: if (rx_data == chk) begin
                        state    <= COMMIT;
                        idx      <= '0;
                        wr_valid <= 1'b1;
                        wr_addr  <= base;
                        wr_data  <= rdata;
                    end else begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_BAD_CHK;
                        state     <= IDLE;
                    end
`endif
                    default: ;
                endcase
            end else if (rx_endofpacket && state != IDLE) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                state     <= IDLE;
            end
        end
    end
endmodule
